// File: rtl/rom_dl_sequencer.sv
// -----------------------------------------------------------------------------
// rom_dl_sequencer
//
// Purpose:
//   Bridges the data_io SPI download engine to the Pacman core's ROM download
//   port. It selects the ROM download by ioctl_index and re-registers each
//   accepted byte onto dn_addr/dn_data/dn_wr with one cycle of latency. It
//   counts the bytes and checks them (exact length, no address gaps) and
//   tracks the load state (EMPTY/LOAD/READY/ERROR). It also generates the core
//   reset, including a hold-off of HOLD_CYCLES after every reset cause clears.
//
// Optional feature (compile-time macro ROM_DL_SEQUENCER_CHECKSUM_EN):
//   Adds parameter EXP_SUM and output port checksum. The checksum is a 16-bit
//   running sum of the accepted bytes. When EXP_SUM is non-zero, READY also
//   requires checksum == EXP_SUM. EXP_SUM == 0 disables the comparison.
//
// Ports:
//   clk_sys      in   1  system clock
//   reset_n      in   1  asynchronous active-low reset
//   ioctl_downl  in   1  download active (data_io)
//   ioctl_index  in   8  download index
//   ioctl_wr     in   1  single-cycle byte write strobe
//   ioctl_addr   in  25  byte address
//   ioctl_dout   in   8  byte data
//   user_reset   in   1  OSD/button reset, level, active-high
//   dn_addr      out 16  core download address
//   dn_data      out  8  core download data
//   dn_wr        out  1  core download write strobe (one cycle per byte)
//   rom_loaded   out  1  a valid ROM set has been loaded
//   load_err     out  1  the last ROM download failed validation
//   core_reset   out  1  active-high core reset
//   checksum     out 16  (macro only) running byte sum of current/last load
//   byte_count   out 17  bytes accepted in the current or last download
// -----------------------------------------------------------------------------
module rom_dl_sequencer #(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [16:0] EXP_BYTES   = 17'h0C000,
  parameter int          HOLD_CYCLES = 16
`ifdef ROM_DL_SEQUENCER_CHECKSUM_EN
  ,
  parameter logic [15:0] EXP_SUM     = 16'h0000
`endif
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        rom_loaded,
  output logic        load_err,
  output logic        core_reset,
`ifdef ROM_DL_SEQUENCER_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic [16:0] byte_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam int              HOLD_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES);

  logic [1:0]        state_q,      state_d;
  logic              sel_q;
  logic              gap_q,        gap_d;
  logic [16:0]       byte_count_q, byte_count_d;
  logic [15:0]       dn_addr_q,    dn_addr_d;
  logic [7:0]        dn_data_q,    dn_data_d;
  logic              dn_wr_q,      dn_wr_d;
  logic              rom_loaded_q, rom_loaded_d;
  logic              load_err_q,   load_err_d;
  logic [HOLD_W-1:0] hold_q,       hold_d;
  logic              core_reset_q, core_reset_d;
`ifdef ROM_DL_SEQUENCER_CHECKSUM_EN
  logic [15:0]       checksum_q,   checksum_d;
`endif

  logic sel;
  logic sel_rise;
  logic sel_fall;
  logic sum_ok;
  logic cause;

  assign sel      = ioctl_downl && (ioctl_index == ROM_INDEX);
  assign sel_rise = sel && !sel_q;
  assign sel_fall = !sel && sel_q;

`ifdef ROM_DL_SEQUENCER_CHECKSUM_EN
  assign sum_ok = (EXP_SUM == 16'h0000) || (checksum_q == EXP_SUM);
`else
  assign sum_ok = 1'b1;
`endif

  // Download state machine and byte path.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    byte_count_d = byte_count_q;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    dn_wr_d      = 1'b0;
    rom_loaded_d = rom_loaded_q;
    load_err_d   = load_err_q;
`ifdef ROM_DL_SEQUENCER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    if (sel_rise && (state_q != ST_LOAD)) begin
      state_d      = ST_LOAD;
      gap_d        = 1'b0;
      byte_count_d = '0;
      rom_loaded_d = 1'b0;
      load_err_d   = 1'b0;
`ifdef ROM_DL_SEQUENCER_CHECKSUM_EN
      checksum_d   = '0;
`endif
    end else if (state_q == ST_LOAD) begin
      if (sel_fall) begin
        if ((byte_count_q == EXP_BYTES) && !gap_q && sum_ok) begin
          state_d      = ST_READY;
          rom_loaded_d = 1'b1;
        end else begin
          state_d    = ST_ERROR;
          load_err_d = 1'b1;
        end
      end else if (sel && ioctl_wr) begin
        if (ioctl_addr[24:16] != 9'd0) begin
          // Beyond the 64 KiB core window: drop it, but the set is now suspect.
          gap_d = 1'b1;
        end else begin
          dn_addr_d = ioctl_addr[15:0];
          dn_data_d = ioctl_dout;
          dn_wr_d   = 1'b1;
          // A valid set is written strictly sequentially from address 0.
          if (ioctl_addr != {8'd0, byte_count_q}) begin
            gap_d = 1'b1;
          end
          if (byte_count_q != 17'h1FFFF) begin
            byte_count_d = byte_count_q + 17'd1;
          end
`ifdef ROM_DL_SEQUENCER_CHECKSUM_EN
          checksum_d = checksum_q + {8'd0, ioctl_dout};
`endif
        end
      end
    end
  end

  // Core reset hold-off. The cause uses the next state so that core_reset
  // reasserts on the same edge that leaves READY and starts counting on the
  // same edge that enters it.
  always_comb begin
    cause = user_reset || (state_d != ST_READY);
    if (cause) begin
      hold_d       = HOLD_RELOAD;
      core_reset_d = 1'b1;
    end else if (hold_q != '0) begin
      hold_d       = hold_q - HOLD_W'(1);
      core_reset_d = 1'b1;
    end else begin
      hold_d       = hold_q;
      core_reset_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      // Resetting the edge detector high means a download already in flight
      // when reset releases is not mistaken for a new one; only a genuine
      // rising edge of sel starts a load.
      sel_q        <= 1'b1;
      gap_q        <= 1'b0;
      byte_count_q <= '0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_wr_q      <= 1'b0;
      rom_loaded_q <= 1'b0;
      load_err_q   <= 1'b0;
      hold_q       <= HOLD_RELOAD;
      core_reset_q <= 1'b1;
`ifdef ROM_DL_SEQUENCER_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel;
      gap_q        <= gap_d;
      byte_count_q <= byte_count_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      rom_loaded_q <= rom_loaded_d;
      load_err_q   <= load_err_d;
      hold_q       <= hold_d;
      core_reset_q <= core_reset_d;
`ifdef ROM_DL_SEQUENCER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign rom_loaded = rom_loaded_q;
  assign load_err   = load_err_q;
  assign core_reset = core_reset_q;
  assign byte_count = byte_count_q;
`ifdef ROM_DL_SEQUENCER_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
- Sits between the data_io SPI download engine and the Pacman-hardware core's ROM download port (dn_addr/dn_data/dn_wr).
- Filters the ioctl stream by index, registers writes into the core, and counts and validates downloaded bytes.
- Tracks download state and generates the core reset, including a hold-off after load and after a user reset.
- Replaces the ad-hoc rom_loaded/reset logic in the arcade top level.

Parameters:
- ROM_INDEX, 8'd0, ioctl_index value that selects the ROM download; other indexes are ignored.
- EXP_BYTES, 17'h0C000, exact byte count of a valid ROM set.
- HOLD_CYCLES, 16, clk_sys cycles core_reset stays asserted after a reset cause clears; minimum 1.

Ports:
- clk_sys, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- ioctl_downl, in, 1, download active, from data_io.
- ioctl_index, in, 8, download index.
- ioctl_wr, in, 1, single-cycle byte write strobe.
- ioctl_addr, in, 25, byte address.
- ioctl_dout, in, 8, byte data.
- user_reset, in, 1, OSD reset or button reset, level, active-high.
- dn_addr, out, 16, core download address.
- dn_data, out, 8, core download data.
- dn_wr, out, 1, core download write strobe.
- rom_loaded, out, 1, a valid ROM set has been loaded.
- load_err, out, 1, the last download failed validation.
- core_reset, out, 1, active-high reset to the core.
- byte_count, out, 17, bytes accepted in the current or last download.

Behaviour:
- Reset values (reset_n low, async):
  - dn_addr=0, dn_data=0, dn_wr=0, rom_loaded=0, load_err=0, core_reset=1, byte_count=0.
  - State is EMPTY; hold counter is loaded with HOLD_CYCLES.
- sel = ioctl_downl && (ioctl_index==ROM_INDEX). Non-matching downloads are ignored entirely: no writes, no state change.
- States: EMPTY, LOAD, READY, ERROR.
  - EMPTY/READY/ERROR -> LOAD on rising edge of sel. On entry: byte_count=0, rom_loaded=0, load_err=0, gap flag cleared.
  - In LOAD, each cycle with sel && ioctl_wr:
    - ioctl_addr[24:16]!=0: the byte is dropped (no dn_wr), gap flag set, byte_count unchanged.
    - Otherwise: dn_addr<=ioctl_addr[15:0], dn_data<=ioctl_dout, dn_wr<=1 for exactly one cycle (1-cycle latency). If ioctl_addr!=byte_count, set gap flag. Then byte_count increments.
    - byte_count saturates at 17'h1FFFF.
  - LOAD -> READY on falling edge of sel when byte_count==EXP_BYTES and the gap flag is clear: rom_loaded<=1.
  - LOAD -> ERROR on falling edge of sel otherwise: load_err<=1, rom_loaded stays 0.
- dn_wr is 0 in every cycle that does not carry an accepted byte. Back-to-back ioctl_wr cycles each produce a dn_wr pulse.
- core_reset:
  - cause = user_reset | (state!=READY).
  - While cause is high: core_reset=1 and the hold counter reloads to HOLD_CYCLES.
  - After cause falls: the counter decrements once per cycle; core_reset deasserts in the cycle after the counter reaches 0. It is 1 for exactly HOLD_CYCLES cycles after the READY entry edge.
  - user_reset mid-hold reloads the counter.
- A new download arriving while READY clears rom_loaded immediately on the sel rising edge; core_reset reasserts in the same cycle.
- reset_n asserted mid-download aborts it: state EMPTY, all outputs at reset values. The remainder of that download is discarded until the next sel rising edge.

Optional Feature:
- Macro: ROM_DL_SEQUENCER_CHECKSUM_EN.
- When defined:
  - Adds parameter EXP_SUM (16 bits, default 16'h0000) and output port checksum (16 bits).
  - checksum is a mod-2^16 sum of all accepted bytes, cleared on LOAD entry and reset to 0.
  - The LOAD -> READY transition additionally requires checksum==EXP_SUM; a mismatch goes to ERROR.
  - EXP_SUM==16'h0000 disables the comparison.
- When undefined: no checksum port, no EXP_SUM, validation uses count and gap only.

Test Plan:
- Power-up, no download:
  - Expected: core_reset=1, rom_loaded=0, dn_wr never pulses.
- Index 0 download, EXP_BYTES=16 in the bench, bytes 0x00..0x0F at addr 0..15:
  - 16 dn_wr pulses, each 1 cycle after ioctl_wr, with matching addr/data.
  - On downl fall: rom_loaded=1, load_err=0, byte_count=16.
  - core_reset drops exactly HOLD_CYCLES cycles later.
- Short download of 15 bytes:
  - Expected: ERROR state, load_err=1, rom_loaded=0, core_reset stays 1.
- Address gap (addr sequence 0,1,3,...) or a byte at addr 0x10000:
  - Gap: load_err=1 at end.
  - 0x10000 byte: no dn_wr for that byte.
- Download with ioctl_index=1 interleaved after READY:
  - Expected: no dn_wr, state stays READY, core_reset stays 0.
- user_reset pulse of 3 cycles while READY:
  - core_reset=1 from the next edge through HOLD_CYCLES cycles after user_reset falls.
  - reset_n pulse mid-LOAD returns all outputs to reset values.
  - With CHECKSUM_EN and EXP_SUM=0x0078 for bytes 0..15: READY; with EXP_SUM=0x0079: ERROR.
